uart_host_sequencer: RTL and testbench

- Host-side command sequencer that sits directly upstream of the UART tapeout wrapper.
- Drives the wrapper's 4-bit control nibble and tx_data bus, and samples its rx_data bus.
- Turns host valid/ready byte streams into correctly timed wrapper commands. The wrapper acts only on an IDLE-to-non-IDLE transition of control[3:2], and uses the command during the following cycle, so each command is issue, hold, then idle gap.
- Arbitrates between write, read and buffer-clear requests.

---
 rtl/uart_host_sequencer.sv | 160 ++++++++++++++++
 tb/tb_uart_host_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_sequencer.sv
// Host-side command sequencer for the UART wrapper: issue/hold/gap timing, clear > read/write arbitration.
// Optional per-direction accept counters are compiled in with UART_SEQ_STATS_EN.
module uart_host_sequencer #(
  parameter int GapCycles = 1,
  parameter int DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           rate_sel,
  input  logic                 host_tx_valid,
  input  logic [DataWidth-1:0] host_tx_data,
  output logic                 host_tx_ready,
  input  logic                 host_rd_req,
  output logic                 host_rd_ready,
  output logic                 host_rd_valid,
  output logic [DataWidth-1:0] host_rd_data,
  input  logic                 host_clear_req,
  output logic                 host_clear_done,
  output logic                 busy,
  output logic [3:0]           uart_control,
  output logic [DataWidth-1:0] uart_tx_data,
  input  logic [DataWidth-1:0] uart_rx_data
`ifdef UART_SEQ_STATS_EN
  ,
  output logic [15:0]          tx_count,
  output logic [15:0]          rx_count
`endif
);

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_TX   = 2'b01;
  localparam logic [1:0] CMD_RX   = 2'b10;
  localparam logic [1:0] CMD_CLR  = 2'b11;
  localparam logic [3:0] GAP_LOAD = 4'(GapCycles - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_gap_cnt;
  logic [3:0]           w_gap_cnt_next;
  logic [1:0]           r_cmd;
  logic [DataWidth-1:0] r_data;
  logic [1:0]           r_rate;
  logic                 r_last_wr;
  logic [DataWidth-1:0] r_rd_data;
  logic                 r_rd_valid;
  logic                 r_clear_done;

  logic w_in_ready;
  logic w_tx_grant;
  logic w_rd_grant;
  logic w_clr_acc;
  logic w_tx_acc;
  logic w_rd_acc;
  logic w_cmd_active;

  // Round-robin: a pending read wins contention when a write was served last, and vice versa.
  assign w_in_ready    = (r_state == S_READY) && !reset;
  assign w_tx_grant    = !host_clear_req && !(host_rd_req && r_last_wr);
  assign w_rd_grant    = !host_clear_req && !(host_tx_valid && !r_last_wr);
  assign host_tx_ready = w_in_ready && w_tx_grant;
  assign host_rd_ready = w_in_ready && w_rd_grant;
  assign w_clr_acc     = w_in_ready && host_clear_req;
  assign w_tx_acc      = host_tx_valid && host_tx_ready;
  assign w_rd_acc      = host_rd_req && host_rd_ready;

  assign w_cmd_active    = (r_state == S_ISSUE) || (r_state == S_HOLD);
  assign uart_control    = {(w_cmd_active ? r_cmd : CMD_IDLE), r_rate};
  assign uart_tx_data    = w_cmd_active ? r_data : '0;
  assign busy            = (r_state != S_READY);
  assign host_rd_data    = r_rd_data;
  assign host_rd_valid   = r_rd_valid;
  assign host_clear_done = r_clear_done;

  always_comb begin
    w_state_next   = r_state;
    w_gap_cnt_next = r_gap_cnt;
    case (r_state)
      S_READY: begin
        if (w_clr_acc || w_tx_acc || w_rd_acc) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: w_state_next = S_HOLD;
      S_HOLD: begin
        w_state_next   = S_GAP;
        w_gap_cnt_next = GAP_LOAD;
      end
      S_GAP: begin
        if (r_gap_cnt == 4'd0) begin
          w_state_next = S_READY;
        end else begin
          w_gap_cnt_next = r_gap_cnt - 4'd1;
        end
      end
      default: w_state_next = S_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_READY;
      r_gap_cnt    <= 4'd0;
      r_cmd        <= CMD_IDLE;
      r_data       <= '0;
      r_rate       <= 2'b00;
      r_last_wr    <= 1'b1;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_gap_cnt    <= w_gap_cnt_next;
      r_rate       <= rate_sel;
      r_rd_valid   <= (r_state == S_HOLD) && (r_cmd == CMD_RX);
      r_clear_done <= (r_state == S_HOLD) && (r_cmd == CMD_CLR);
      if ((r_state == S_HOLD) && (r_cmd == CMD_RX)) begin
        r_rd_data <= uart_rx_data;
      end
      if (w_clr_acc) begin
        r_cmd  <= CMD_CLR;
        r_data <= '0;
      end else if (w_rd_acc) begin
        r_cmd     <= CMD_RX;
        r_data    <= '0;
        r_last_wr <= 1'b0;
      end else if (w_tx_acc) begin
        r_cmd     <= CMD_TX;
        r_data    <= host_tx_data;
        r_last_wr <= 1'b1;
      end
    end
  end

`ifdef UART_SEQ_STATS_EN
  logic [15:0] r_tx_count;
  logic [15:0] r_rx_count;

  // A clear accept wipes both counters even if an increment would land the same cycle.
  always_ff @(posedge clk) begin
    if (reset || w_clr_acc) begin
      r_tx_count <= 16'd0;
      r_rx_count <= 16'd0;
    end else begin
      if (w_tx_acc) r_tx_count <= r_tx_count + 16'd1;
      if (w_rd_acc) r_rx_count <= r_rx_count + 16'd1;
    end
  end

  assign tx_count = r_tx_count;
  assign rx_count = r_rx_count;
`endif

endmodule

// File: tb/tb_uart_host_sequencer.sv
// Directed bench for uart_host_sequencer: command scoreboard on the wrapper side, read-data scoreboard on the host side.
// A second instance with GapCycles=3 checks the stretched idle gap.
module tb_uart_host_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rate_sel;
  logic       host_tx_valid;
  logic [7:0] host_tx_data;
  logic       host_tx_ready;
  logic       host_rd_req;
  logic       host_rd_ready;
  logic       host_rd_valid;
  logic [7:0] host_rd_data;
  logic       host_clear_req;
  logic       host_clear_done;
  logic       busy;
  logic [3:0] uart_control;
  logic [7:0] uart_tx_data;
  logic [7:0] uart_rx_data;

  logic       g_tx_valid;
  logic [7:0] g_tx_data;
  logic       g_tx_ready;
  logic       g_rd_ready;
  logic       g_rd_valid;
  logic [7:0] g_rd_data;
  logic       g_clear_done;
  logic       g_busy;
  logic [3:0] g_ctrl;
  logic [7:0] g_txd;

`ifdef UART_SEQ_STATS_EN
  logic [15:0] tx_count, rx_count, g_tx_count, g_rx_count;
`endif

  always #5 clk = ~clk;

  uart_host_sequencer #(.GapCycles(1), .DataWidth(8)) dut (
    .clk(clk), .reset(reset), .rate_sel(rate_sel),
    .host_tx_valid(host_tx_valid), .host_tx_data(host_tx_data), .host_tx_ready(host_tx_ready),
    .host_rd_req(host_rd_req), .host_rd_ready(host_rd_ready),
    .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
    .host_clear_req(host_clear_req), .host_clear_done(host_clear_done), .busy(busy),
    .uart_control(uart_control), .uart_tx_data(uart_tx_data), .uart_rx_data(uart_rx_data)
`ifdef UART_SEQ_STATS_EN
    , .tx_count(tx_count), .rx_count(rx_count)
`endif
  );

  uart_host_sequencer #(.GapCycles(3), .DataWidth(8)) dut3 (
    .clk(clk), .reset(reset), .rate_sel(rate_sel),
    .host_tx_valid(g_tx_valid), .host_tx_data(g_tx_data), .host_tx_ready(g_tx_ready),
    .host_rd_req(1'b0), .host_rd_ready(g_rd_ready),
    .host_rd_valid(g_rd_valid), .host_rd_data(g_rd_data),
    .host_clear_req(1'b0), .host_clear_done(g_clear_done), .busy(g_busy),
    .uart_control(g_ctrl), .uart_tx_data(g_txd), .uart_rx_data(8'h00)
`ifdef UART_SEQ_STATS_EN
    , .tx_count(g_tx_count), .rx_count(g_rx_count)
`endif
  );

  typedef struct packed {
    logic [1:0] code;
    logic [7:0] data;
  } cmd_t;

  cmd_t       exp_cmd[$];
  logic [7:0] exp_rd[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] code, input logic [7:0] data);
    cmd_t c;
    c.code = code;
    c.data = data;
    exp_cmd.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit rd);
    int i;
    for (i = 0; i < 32; i++) begin
      #1;
      if (rd ? host_rd_ready : host_tx_ready) break;
      tick();
    end
    check("ready_wait", (i < 32), 1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 32; i++) begin
      if (!busy) break;
      tick();
    end
    check("idle_wait", (i < 32), 1);
  endtask

  task automatic do_write(input logic [7:0] d);
    push_cmd(2'b01, d);
    host_tx_valid = 1'b1;
    host_tx_data  = d;
    wait_ready(1'b0);
    tick();
    host_tx_valid = 1'b0;
    host_tx_data  = ~d;
    wait_idle();
  endtask

  task automatic do_read(input logic [7:0] rx);
    push_cmd(2'b10, 8'h00);
    exp_rd.push_back(rx);
    uart_rx_data = rx;
    host_rd_req  = 1'b1;
    wait_ready(1'b1);
    tick();
    host_rd_req = 1'b0;
    wait_idle();
  endtask

  // Wrapper-side monitor: every IDLE->command edge must match the next queued command.
  cmd_t mon_e;
  int   mon_prev = 0, mon_run = 0, mon_idle = 0, mon_seen = 0, mon_clr = 0;
  always @(negedge clk) begin
    if (reset) begin
      mon_prev = 0;
      mon_run  = 0;
      mon_idle = 0;
      mon_seen = 0;
    end else begin
      if (uart_control[3:2] != 2'b00) begin
        if (mon_prev == 0) begin
          if (mon_seen != 0) check("gap_len", (mon_idle >= 1), 1);
          if (exp_cmd.size() == 0) begin
            check("cmd_unexpected", uart_control[3:2], 0);
          end else begin
            mon_e = exp_cmd.pop_front();
            check("cmd_code", uart_control[3:2], mon_e.code);
            check("cmd_data", uart_tx_data, mon_e.data);
          end
          mon_run  = 1;
          mon_seen = 1;
        end else begin
          mon_run++;
        end
        mon_idle = 0;
      end else begin
        if (mon_prev != 0) check("cmd_hold_len", mon_run, 2);
        mon_idle++;
      end
      mon_prev = int'(uart_control[3:2]);
      if (host_rd_valid) begin
        if (exp_rd.size() == 0) check("rd_unexpected", host_rd_valid, 0);
        else check("rd_data", host_rd_data, exp_rd.pop_front());
      end
      if (host_clear_done) mon_clr++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [1:0] gexp_code [8] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
  logic [7:0] gexp_data [8] = '{8'h11, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22, 8'h22};

  initial begin
    reset          = 1'b1;
    rate_sel       = 2'b10;
    host_tx_valid  = 1'b0;
    host_tx_data   = 8'h00;
    host_rd_req    = 1'b0;
    host_clear_req = 1'b0;
    uart_rx_data   = 8'h00;
    g_tx_valid     = 1'b0;
    g_tx_data      = 8'h00;

    // Reset state
    tick();
    tick();
    check("rst_tx_ready", host_tx_ready, 0);
    check("rst_rd_ready", host_rd_ready, 0);
    check("rst_control", uart_control, 4'h0);
    check("rst_tx_data", uart_tx_data, 8'h00);
    check("rst_rd_data", host_rd_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", host_rd_valid, 0);
    check("rst_clear_done", host_clear_done, 0);
    reset = 1'b0;
    tick();
    check("rate_field", uart_control, 4'b0010);
    check("idle_tx_ready", host_tx_ready, 1);

    // Contention: clear first, then read (reset says write was last), then alternate
    uart_rx_data   = 8'h5A;
    host_tx_data   = 8'h77;
    host_tx_valid  = 1'b1;
    host_rd_req    = 1'b1;
    host_clear_req = 1'b1;
    push_cmd(2'b11, 8'h00);
    push_cmd(2'b10, 8'h00);
    push_cmd(2'b01, 8'h77);
    push_cmd(2'b10, 8'h00);
    push_cmd(2'b01, 8'h77);
    exp_rd.push_back(8'h5A);
    exp_rd.push_back(8'h5A);
    #1;
    check("clr_blocks_tx", host_tx_ready, 0);
    check("clr_blocks_rd", host_rd_ready, 0);
    tick();
    host_clear_req = 1'b0;
    check("clr_issue", uart_control[3:2], 2'b11);
    for (int i = 0; i < 60 && exp_cmd.size() != 0; i++) tick();
    host_tx_valid = 1'b0;
    host_rd_req   = 1'b0;
    check("contention_drained", exp_cmd.size(), 0);
    wait_idle();
    tick();
    check("clear_done_once", mon_clr, 1);
    check("contention_rd_left", exp_rd.size(), 0);

    // Single write with exact cycle timing; host data changes after accept are ignored
    push_cmd(2'b01, 8'hA5);
    host_tx_valid = 1'b1;
    host_tx_data  = 8'hA5;
    wait_ready(1'b0);
    tick();
    host_tx_valid = 1'b0;
    host_tx_data  = 8'h3F;
    check("wr_issue_ctrl", uart_control[3:2], 2'b01);
    check("wr_issue_busy", busy, 1);
    tick();
    check("wr_hold_ctrl", uart_control[3:2], 2'b01);
    check("wr_hold_data", uart_tx_data, 8'hA5);
    tick();
    check("wr_gap_ctrl", uart_control[3:2], 2'b00);
    check("wr_gap_data", uart_tx_data, 8'h00);
    check("wr_gap_ready", host_tx_ready, 0);
    tick();
    check("wr_ready_back", host_tx_ready, 1);
    check("wr_busy_clear", busy, 0);

    // Single read: data captured from the wrapper bus during HOLD
    push_cmd(2'b10, 8'h00);
    exp_rd.push_back(8'h3C);
    uart_rx_data = 8'h3C;
    host_rd_req  = 1'b1;
    wait_ready(1'b1);
    tick();
    host_rd_req = 1'b0;
    check("rd_issue_ctrl", uart_control[3:2], 2'b10);
    check("rd_issue_valid", host_rd_valid, 0);
    tick();
    check("rd_hold_ctrl", uart_control[3:2], 2'b10);
    tick();
    uart_rx_data = 8'h99;
    check("rd_valid_pulse", host_rd_valid, 1);
    check("rd_data_value", host_rd_data, 8'h3C);
    tick();
    check("rd_valid_drop", host_rd_valid, 0);
    check("rd_data_held", host_rd_data, 8'h3C);

    // Gap length on the GapCycles=3 instance, back-to-back writes
    g_tx_valid = 1'b1;
    g_tx_data  = 8'h11;
    begin
      int i;
      for (i = 0; i < 32; i++) begin
        #1;
        if (g_tx_ready) break;
        tick();
      end
      check("g_ready_wait", (i < 32), 1);
    end
    tick();
    g_tx_data = 8'h22;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("gap3_code_%0d", k), g_ctrl[3:2], gexp_code[k]);
      check($sformatf("gap3_data_%0d", k), g_txd, gexp_data[k]);
      if (k == 6) g_tx_valid = 1'b0;
      tick();
    end

    // Reset during HOLD of a read: abort with no rd_valid
    rate_sel = 2'b01;
    push_cmd(2'b10, 8'h00);
    uart_rx_data = 8'h44;
    host_rd_req  = 1'b1;
    wait_ready(1'b1);
    tick();
    host_rd_req = 1'b0;
    tick();
    check("abort_hold_ctrl", uart_control[3:2], 2'b10);
    reset         = 1'b1;
    rate_sel      = 2'b11;
    host_tx_valid = 1'b1;
    #1;
    check("abort_tx_ready", host_tx_ready, 0);
    check("abort_rd_ready", host_rd_ready, 0);
    tick();
    check("abort_ctrl", uart_control, 4'h0);
    check("abort_busy", busy, 0);
    check("abort_rd_valid", host_rd_valid, 0);
    host_tx_valid = 1'b0;
    reset         = 1'b0;
    tick();
    check("abort_rate", uart_control, 4'b0011);
    check("abort_rd_valid2", host_rd_valid, 0);
    tick();
    check("abort_rd_valid3", host_rd_valid, 0);

    // Plain reads/writes, also exercising the optional counters
    do_write(8'h01);
    do_write(8'h02);
    do_read(8'hC1);
    do_write(8'h03);
    do_read(8'hC2);
`ifdef UART_SEQ_STATS_EN
    check("stats_tx", tx_count, 16'd3);
    check("stats_rx", rx_count, 16'd2);
`endif
    push_cmd(2'b11, 8'h00);
    host_clear_req = 1'b1;
    #1;
    tick();
    host_clear_req = 1'b0;
    check("clr2_issue", uart_control[3:2], 2'b11);
`ifdef UART_SEQ_STATS_EN
    check("stats_tx_clr", tx_count, 16'd0);
    check("stats_rx_clr", rx_count, 16'd0);
`endif
    wait_idle();
    tick();
    check("clear_done_total", mon_clr, 2);
    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
